// File: rtl/aes_arbiter.sv
// -----------------------------------------------------------------------------
// aes_arbiter
//   Two-port round-robin arbiter/sequencer in front of a single AES core.
//   One operation is outstanding at a time: a request is accepted in IDLE,
//   issued to the core as a one-cycle enable pulse, the core's ready is awaited
//   under a watchdog, and the result is held for the owning port until that
//   port accepts it.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready     per-port request handshake (bit i = port i)
//   req_func0/1, req_data0/1  per-port operation code and operand
//   resp_valid/resp_ready   per-port response handshake
//   resp_data, resp_error   shared result and timeout flag, qualified by resp_valid
//   aes_in                  to core: data, func, enable
//   aes_out                 from core: data, ready
// -----------------------------------------------------------------------------
package aes_arbiter_pkg;

  typedef struct packed {
    logic [255:0] data;
    logic [1:0]   func;
    logic         enable;
  } aes_in_type;

  typedef struct packed {
    logic [255:0] data;
    logic         ready;
  } aes_out_type;

endpackage

module aes_arbiter
  import aes_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [1:0]   req_func0,
  input  logic [1:0]   req_func1,
  input  logic [255:0] req_data0,
  input  logic [255:0] req_data1,
  output logic [1:0]   resp_valid,
  input  logic [1:0]   resp_ready,
  output logic [255:0] resp_data,
  output logic         resp_error,
  output aes_in_type   aes_in,
  input  aes_out_type  aes_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT - 1);

  state_t       r_state;
  state_t       w_state_next;
  logic         r_last_grant;
  logic         r_owner;
  logic [15:0]  r_cnt;
  logic [1:0]   r_func;
  logic [255:0] r_data;
  logic [255:0] r_result;
  logic         r_error;

  logic         w_grant;
  logic         w_req_fire;
  logic         w_timeout;
  logic         w_resp_fire;

  // A lone requester wins outright; on a tie the port that was not served
  // last goes next.
  assign w_grant     = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
  assign req_ready   = (r_state == S_IDLE && req_valid != 2'b00)
                       ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  assign w_req_fire  = (req_valid & req_ready) != 2'b00;
  assign w_timeout   = (r_cnt == LP_CNT_LAST);
  assign w_resp_fire = resp_ready[r_owner];

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req_fire) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      // ready and timeout in the same cycle both leave WAIT; the datapath
      // below gives ready priority so the core's result is kept.
      S_WAIT:  if (aes_out.ready || w_timeout) w_state_next = S_RESP;
      S_RESP:  if (w_resp_fire) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of block order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: the wide operand/result registers are reset too, because aes_in
  // and resp_data must read zero straight out of reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_cnt        <= '0;
      r_func       <= '0;
      r_data       <= '0;
      r_result     <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req_fire) begin
            r_owner <= w_grant;
            r_func  <= w_grant ? req_func1 : req_func0;
            r_data  <= w_grant ? req_data1 : req_data0;
          end
        end
        S_ISSUE: r_cnt <= '0;
        S_WAIT: begin
          if (aes_out.ready) begin
            r_result <= aes_out.data;
            r_error  <= 1'b0;
          end else if (w_timeout) begin
            r_result <= '0;
            r_error  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_RESP: if (w_resp_fire) r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

  assign aes_in.data   = r_data;
  assign aes_in.func   = r_func;
  assign aes_in.enable = (r_state == S_ISSUE);

  assign resp_valid = (r_state == S_RESP) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data  = r_result;
  assign resp_error = r_error;

endmodule

// File: tb/tb_aes_arbiter.sv
// -----------------------------------------------------------------------------
// tb_aes_arbiter
//   Self-checking bench for aes_arbiter (TIMEOUT = 8). A transaction-level
//   reference model predicts every cycle's outputs from acceptance timestamps:
//   enable at T+1, response at T+2+d when the core answers d cycles after
//   enable (d in 1..TIMEOUT), otherwise an error response at T+2+TIMEOUT.
// -----------------------------------------------------------------------------
module tb_aes_arbiter;
  import aes_arbiter_pkg::*;

  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready, req_func0, req_func1;
  logic [255:0] req_data0, req_data1;
  logic [1:0]   resp_valid, resp_ready;
  logic [255:0] resp_data;
  logic         resp_error;
  aes_in_type   aes_in;
  aes_out_type  aes_out;

  aes_arbiter #(.TIMEOUT(TO)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_func0  (req_func0),
    .req_func1  (req_func1),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_error (resp_error),
    .aes_in     (aes_in),
    .aes_out    (aes_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // reference model: free/busy plus timestamps of the outstanding operation
  bit           m_busy;
  int           m_owner, m_last, m_t, m_resp_at, m_ready_at;
  logic [1:0]   m_func;
  logic [255:0] m_data, m_res, m_core_data;
  bit           m_err;
  int           accepts;

  // requesters: a request stays valid until accepted
  bit           pend [2];
  logic [1:0]   p_func [2];
  logic [255:0] p_data [2];

  // stimulus policy
  int           req_prob;      // % chance per cycle an idle port raises a request
  int           rr_mode;       // 0 random resp_ready, 1 always ready, 2 hold off
  int           hold;          // cycles resp_ready stays low in mode 2
  int           delay_mode;    // 0 random core delay, 1 fixed_delay
  int           fixed_delay;   // 0 means the core never answers
  bit           fixed_cdata_en;
  logic [255:0] fixed_cdata;
  bit           stray_en;      // random ready pulses outside the wait window
  int           grant_q [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // one clock cycle: drive at negedge, compare 1 ns later, advance the model
  task automatic step();
    logic [1:0] exp_rr, exp_rv, hs;
    bit         in_window;
    int         g, d;
    @(negedge clock);
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && int'($urandom_range(99)) < req_prob) begin
        pend[p]   = 1'b1;
        p_func[p] = 2'($urandom);
        p_data[p] = rand256();
      end
    end
    req_valid = {pend[1], pend[0]};
    req_func0 = p_func[0];
    req_func1 = p_func[1];
    req_data0 = p_data[0];
    req_data1 = p_data[1];
    case (rr_mode)
      0:       resp_ready = 2'($urandom);
      1:       resp_ready = 2'b11;
      default: resp_ready = (m_busy && cyc >= m_resp_at + hold) ? 2'b11 : 2'b00;
    endcase
    in_window = m_busy && cyc >= m_t + 2 && cyc < m_resp_at;
    if (in_window) begin
      aes_out.ready = (cyc == m_ready_at);
      aes_out.data  = (cyc == m_ready_at) ? m_core_data : rand256();
    end else begin
      aes_out.ready = stray_en && ($urandom_range(2) == 0);
      aes_out.data  = rand256();
    end

    exp_rr = 2'b00;
    if (!m_busy) begin
      case (req_valid)
        2'b01:   exp_rr = 2'b01;
        2'b10:   exp_rr = 2'b10;
        2'b11:   exp_rr = (m_last == 0) ? 2'b10 : 2'b01;
        default: exp_rr = 2'b00;
      endcase
    end
    exp_rv = (m_busy && cyc >= m_resp_at) ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;

    #1;
    check("req_ready",  256'(req_ready),     256'(exp_rr));
    check("enable",     256'(aes_in.enable), 256'(m_busy && cyc == m_t + 1));
    check("aes_func",   256'(aes_in.func),   256'(m_func));
    check("aes_data",   aes_in.data,         m_data);
    check("resp_valid", 256'(resp_valid),    256'(exp_rv));
    if (exp_rv != 2'b00) begin
      check("resp_data",  resp_data,          m_res);
      check("resp_error", 256'(resp_error),   256'(m_err));
    end

    hs = req_valid & req_ready;
    if (hs == 2'b01)      grant_q.push_back(0);
    else if (hs == 2'b10) grant_q.push_back(1);
    else if (hs == 2'b11) grant_q.push_back(2);

    if (!m_busy && exp_rr != 2'b00) begin
      g         = exp_rr[1] ? 1 : 0;
      m_busy    = 1'b1;
      m_owner   = g;
      m_t       = cyc;
      m_func    = p_func[g];
      m_data    = p_data[g];
      pend[g]   = 1'b0;
      accepts++;
      d = (delay_mode == 0) ? int'($urandom_range(0, TO + 2)) : fixed_delay;
      m_core_data = fixed_cdata_en ? fixed_cdata : rand256();
      if (d >= 1 && d <= TO) begin
        m_ready_at = cyc + 1 + d;
        m_resp_at  = cyc + 2 + d;
        m_res      = m_core_data;
        m_err      = 1'b0;
      end else begin
        m_ready_at = -1;
        m_resp_at  = cyc + 2 + TO;
        m_res      = '0;
        m_err      = 1'b1;
      end
    end else if (m_busy && cyc >= m_resp_at && resp_ready[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end
    cyc++;
  endtask

  task automatic run_ops(input int n);
    int target;
    target = accepts + n;
    for (int k = 0; k < 2000 && (accepts < target || m_busy); k++) step();
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_last = 1;
    m_func = '0;
    m_data = '0;
  endtask

  // asynchronous reset between edges while an operation is in WAIT
  task automatic reset_mid();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_resp_valid", 256'(resp_valid),    256'(2'b00));
    check("rst_enable",     256'(aes_in.enable), 256'(1'b0));
    check("rst_aes_data",   aes_in.data,         256'(0));
    check("rst_resp_data",  resp_data,           256'(0));
    @(posedge clock);
    #2 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_func0  = '0;
    req_func1  = '0;
    req_data0  = '0;
    req_data1  = '0;
    resp_ready = '0;
    aes_out    = '0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; p_func[p] = '0; p_data[p] = '0;
    end
    model_reset();
    m_owner = 0; m_t = -10; m_resp_at = 0; m_ready_at = -1;
    m_res = '0; m_err = 1'b0; m_core_data = '0; accepts = 0;
    req_prob = 0; rr_mode = 1; hold = 0; delay_mode = 1; fixed_delay = 5;
    fixed_cdata_en = 1'b1; fixed_cdata = 256'hAB; stray_en = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("reset_resp_valid", 256'(resp_valid),    256'(2'b00));
    check("reset_resp_data",  resp_data,           256'(0));
    check("reset_resp_error", 256'(resp_error),    256'(1'b0));
    check("reset_enable",     256'(aes_in.enable), 256'(1'b0));
    check("reset_aes_func",   256'(aes_in.func),   256'(2'b00));
    check("reset_aes_data",   aes_in.data,         256'(0));
    check("reset_req_ready",  256'(req_ready),     256'(2'b00));
    reset = 1'b0;

    // single request: func 01, data 1, core answers 5 cycles after enable
    pend[0] = 1'b1; p_func[0] = 2'b01; p_data[0] = 256'h1;
    run_ops(1);

    // backpressure: both pending, port 1 wins the tie, holds resp_ready low 10 cycles
    fixed_cdata_en = 1'b0; fixed_delay = 2; rr_mode = 2; hold = 10;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b1; p_func[p] = 2'($urandom); p_data[p] = rand256();
    end
    run_ops(2);

    // timeout, then a normal operation
    rr_mode = 1; fixed_delay = 0;
    pend[0] = 1'b1; p_func[0] = 2'b10; p_data[0] = rand256();
    run_ops(1);
    fixed_delay = 3;
    pend[1] = 1'b1; p_func[1] = 2'b11; p_data[1] = rand256();
    run_ops(1);

    // ready in the same cycle as the last watchdog count, with stray readies
    fixed_delay = TO; stray_en = 1'b1; req_prob = 100;
    run_ops(3);

    // reset while in WAIT
    req_prob = 0; fixed_delay = 0; stray_en = 1'b0;
    pend[0] = 1'b1; p_data[0] = rand256();
    for (int k = 0; k < 100 && !(m_busy && cyc >= m_t + 4); k++) step();
    reset_mid();

    // round-robin from reset: both ports always requesting
    req_prob = 100; delay_mode = 0; grant_q.delete();
    run_ops(4);
    check("rr_count", 256'(grant_q.size()), 256'(4));
    for (int i = 0; i < 4; i++)
      check("rr_grant", 256'((i < grant_q.size()) ? grant_q[i] : 9), 256'(i % 2));

    // random traffic
    req_prob = 40; rr_mode = 0; stray_en = 1'b1;
    for (int k = 0; k < 600; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
